// File: rtl/fls_seq_ctrl.sv
// fls_seq_ctrl: sequencer that drives an FLS Fibonacci-like datapath.
// On an accepted start it clears FLS, feeds seed0 then seed1 through fls_en/fls_d,
// then keeps pulsing fls_en with fls_d=0 until n_terms terms have been captured
// or a captured term reports carry-out. Every captured term is streamed out with
// its 0-based index.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, abort       command inputs (start sampled only in IDLE)
//   seed0, seed1       first two terms, latched on accepted start
//   n_terms            terms to produce including seeds, latched on start
//   busy, done         sequence running / one-cycle completion pulse
//   overflow           sticky carry-out flag, cleared on accepted start
//   term_valid, term, term_idx   captured term stream
//   fls_rst, fls_en, fls_d       to FLS
//   fls_f, fls_cf                from FLS
module fls_seq_ctrl #(
  parameter int unsigned W        = 8,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned RESP_LAT = 1,
  parameter int unsigned GAP      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     seed0,
  input  logic [W-1:0]     seed1,
  input  logic [CNT_W-1:0] n_terms,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             term_valid,
  output logic [W-1:0]     term,
  output logic [CNT_W-1:0] term_idx,
  output logic             fls_rst,
  output logic             fls_en,
  output logic [W-1:0]     fls_d,
  input  logic [W-1:0]     fls_f,
  input  logic             fls_cf
);

  // One shared timer serves both WAIT and GAP; it restarts on every state change.
  localparam int unsigned TmrMax = (RESP_LAT > GAP) ? RESP_LAT : GAP;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StPulse,
    StWait,
    StGap,
    StFin
  } state_e;

  state_e             state_q, state_d;
  logic [TmrW-1:0]    tmr_q;
  logic [CNT_W-1:0]   idx_q;
  logic [W-1:0]       seed0_q, seed1_q;
  logic [CNT_W-1:0]   n_terms_q;
  logic               overflow_q;
  logic               term_valid_q;
  logic [W-1:0]       term_q;
  logic [CNT_W-1:0]   term_idx_q;
  logic [W-1:0]       fls_d_q;
  logic [W-1:0]       pulse_d;

  logic wait_last, gap_last, last_term, capture;

  assign wait_last = (tmr_q == TmrW'(RESP_LAT - 1));
  assign gap_last  = (tmr_q == TmrW'(GAP - 1));
  // Compare one bit wider so idx+1 cannot wrap when n_terms is all ones.
  assign last_term = (({1'b0, idx_q} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, n_terms_q});
  // An abort landing on the capture edge suppresses the capture.
  assign capture   = (state_q == StWait) && wait_last && !abort;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks every transition outside IDLE.
  always_comb begin
    state_d = state_q;
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start) state_d = StClr;
        StClr:   state_d = (n_terms_q == '0) ? StFin : StPulse;
        StPulse: state_d = StWait;
        StWait:  if (wait_last) state_d = StGap;
        StGap: begin
          if (gap_last) state_d = (overflow_q || last_term) ? StFin : StPulse;
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StFin);
    fls_en  = (state_q == StPulse);
    fls_rst = rst || (state_q == StClr);
  end

  // Data to present on the upcoming pulse: seed0 for idx 0 (entered from CLR),
  // seed1 for idx 1, zero afterwards.
  always_comb begin
    pulse_d = '0;
    if (state_q == StClr) begin
      pulse_d = seed0_q;
    end else if (idx_q == '0) begin
      pulse_d = seed1_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q        <= '0;
      idx_q        <= '0;
      seed0_q      <= '0;
      seed1_q      <= '0;
      n_terms_q    <= '0;
      overflow_q   <= 1'b0;
      term_valid_q <= 1'b0;
      term_q       <= '0;
      term_idx_q   <= '0;
      fls_d_q      <= '0;
    end else begin
      term_valid_q <= capture;

      if ((state_q == StIdle) && start) begin
        seed0_q    <= seed0;
        seed1_q    <= seed1;
        n_terms_q  <= n_terms;
        overflow_q <= 1'b0;
      end

      if (capture) begin
        term_q     <= fls_f;
        term_idx_q <= idx_q;
        if (fls_cf) overflow_q <= 1'b1;
      end

      if (((state_q == StWait) || (state_q == StGap)) && (state_d == state_q)) begin
        tmr_q <= tmr_q + 1'b1;
      end else begin
        tmr_q <= '0;
      end

      if (state_q == StClr) begin
        idx_q <= '0;
      end else if ((state_q == StGap) && (state_d == StPulse)) begin
        idx_q <= idx_q + 1'b1;
      end

      // fls_d changes only when a pulse is about to start and holds in between.
      if (state_d == StPulse) begin
        fls_d_q <= pulse_d;
      end
    end
  end

  assign overflow   = overflow_q;
  assign term_valid = term_valid_q;
  assign term       = term_q;
  assign term_idx   = term_idx_q;
  assign fls_d      = fls_d_q;

endmodule
